// File: rtl/fir_meter_pkg.sv
// Shared constants and types for the FIR level meter: sample limits, the accumulator
// slice position, and the tone detector state encoding.
package fir_meter_pkg;

  localparam int unsigned FIR_W     = 48;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned SLICE_MSB = 35;
  localparam int unsigned SLICE_LSB = 20;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    StQuiet  = 2'd0,
    StActive = 2'd1,
    StHold   = 2'd2
  } meter_state_e;

endpackage

// File: rtl/fir_out_sat.sv
// Combinational accumulator-to-sample conversion: slices fir_out, saturates to 16 bits and
// reports the magnitude (with -32768 folded onto 32767).
module fir_out_sat
  import fir_meter_pkg::*;
(
  input  logic        [FIR_W-1:0]    i_fir,
  output logic signed [SAMPLE_W-1:0] o_sample,
  output logic        [SAMPLE_W-1:0] o_mag,
  output logic                       o_sat
);

  logic [FIR_W-1:SLICE_MSB] w_hi;

  assign w_hi  = i_fir[FIR_W-1:SLICE_MSB];
  // The slice is representable only if every bit above it matches its sign bit.
  assign o_sat = !((&w_hi) || (~|w_hi));

  always_comb begin
    o_sample = i_fir[SLICE_MSB:SLICE_LSB];
    if (o_sat) begin
      o_sample = i_fir[FIR_W-1] ? SAMPLE_MIN : SAMPLE_MAX;
    end
  end

  always_comb begin
    o_mag = o_sample;
    if (o_sample == SAMPLE_MIN) begin
      o_mag = SAMPLE_MAX;
    end else if (o_sample[SAMPLE_W-1]) begin
      o_mag = -o_sample;
    end
  end

endmodule

// File: rtl/fir_level_meter.sv
// Captures FIR results on fir_rdy rising edges, emits saturated samples, and reports the
// per-window peak magnitude with a clip flag and a hysteretic tone detector.
module fir_level_meter
  import fir_meter_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 10,
  parameter int unsigned THR_ON   = 8000,
  parameter int unsigned THR_OFF  = 4000,
  parameter int unsigned HOLD_WIN = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic        [FIR_W-1:0]    fir_out,
  input  logic                       fir_rdy,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_vld,
  output logic        [SAMPLE_W-1:0] peak,
  output logic                       peak_vld,
  output logic                       clip,
  output logic                       tone
);

  localparam logic [SAMPLE_W-1:0] ThrOnW   = SAMPLE_W'(THR_ON);
  localparam logic [SAMPLE_W-1:0] ThrOffW  = SAMPLE_W'(THR_OFF);
  localparam logic [3:0]          HoldWinW = 4'(HOLD_WIN);

  logic                       r_rdy;
  logic signed [SAMPLE_W-1:0] r_sample;
  logic                       r_sample_vld;
  logic        [SAMPLE_W-1:0] r_mag;
  logic                       r_sat;
  logic        [WIN_LOG2-1:0] r_cnt;
  logic        [SAMPLE_W-1:0] r_max;
  logic                       r_win_sat;
  logic        [SAMPLE_W-1:0] r_peak;
  logic                       r_peak_vld;
  logic                       r_clip;
  meter_state_e               r_state;
  logic        [3:0]          r_hold;

  logic                       w_cap;
  logic signed [SAMPLE_W-1:0] w_sample;
  logic        [SAMPLE_W-1:0] w_mag;
  logic                       w_sat;
  logic                       w_last;
  logic        [SAMPLE_W-1:0] w_max_new;
  logic                       w_sat_new;
  meter_state_e               w_state_nxt;
  logic        [3:0]          w_hold_nxt;

  fir_out_sat u_sat (
    .i_fir    (fir_out),
    .o_sample (w_sample),
    .o_mag    (w_mag),
    .o_sat    (w_sat)
  );

  assign w_cap     = fir_rdy && !r_rdy;
  assign w_last    = r_sample_vld && (r_cnt == '1);
  assign w_max_new = (r_mag > r_max) ? r_mag : r_max;
  assign w_sat_new = r_win_sat || r_sat;

  // Edge-detect register resets high so a level already present at release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy        <= 1'b1;
      r_sample     <= '0;
      r_sample_vld <= 1'b0;
      r_mag        <= '0;
      r_sat        <= 1'b0;
    end else begin
      r_rdy        <= fir_rdy;
      r_sample_vld <= w_cap;
      if (w_cap) begin
        r_sample <= w_sample;
        r_mag    <= w_mag;
        r_sat    <= w_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_max      <= '0;
      r_win_sat  <= 1'b0;
      r_peak     <= '0;
      r_peak_vld <= 1'b0;
      r_clip     <= 1'b0;
    end else begin
      r_peak_vld <= w_last;
      if (r_sample_vld) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_max     <= '0;
          r_win_sat <= 1'b0;
          r_peak    <= w_max_new;
          r_clip    <= w_sat_new;
        end else begin
          r_max     <= w_max_new;
          r_win_sat <= w_sat_new;
        end
      end
    end
  end

  // The detector steps on the same edge that loads peak, so tone and peak move together.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    if (w_last) begin
      unique case (r_state)
        StQuiet: begin
          if (w_max_new >= ThrOnW) begin
            w_state_nxt = StActive;
          end
        end
        StActive: begin
          if (w_max_new < ThrOffW) begin
            if (HOLD_WIN == 1) begin
              w_state_nxt = StQuiet;
              w_hold_nxt  = '0;
            end else begin
              w_state_nxt = StHold;
              w_hold_nxt  = 4'd1;
            end
          end
        end
        StHold: begin
          if (w_max_new >= ThrOffW) begin
            w_state_nxt = StActive;
            w_hold_nxt  = '0;
          end else if (r_hold + 4'd1 >= HoldWinW) begin
            w_state_nxt = StQuiet;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold + 4'd1;
          end
        end
        default: begin
          w_state_nxt = StQuiet;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StQuiet;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign sample     = r_sample;
  assign sample_vld = r_sample_vld;
  assign peak       = r_peak;
  assign peak_vld   = r_peak_vld;
  assign clip       = r_clip;
  assign tone       = (r_state == StActive) || (r_state == StHold);

endmodule

// File: doc/fir_level_meter.md
FIR_LEVEL_METER -- requirements
Module: fir_level_meter

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 10, log2 of samples per measurement window.
REQ-002 SHALL have parameter THR_ON, default 8000, peak level that asserts tone.
REQ-003 SHALL have parameter THR_OFF, default 4000, peak level below which a window counts as quiet.
REQ-004 SHALL have parameter HOLD_WIN, default 2 (range 1..15), consecutive quiet windows needed to drop tone.
REQ-005 SHALL have ports: clk  in  1  filter clock, same domain as the FIR stage; reset  in  1  asynchronous, active-high.
REQ-006 SHALL have ports: fir_out  in  48  signed FIR accumulator output; fir_rdy  in  1  FIR result-ready flag.
REQ-007 SHALL have ports: sample  out  16  signed saturated audio sample; sample_vld  out  1  one-cycle strobe.
REQ-008 SHALL have ports: peak  out  16  unsigned window peak magnitude; peak_vld  out  1  one-cycle strobe; clip  out  1  saturation seen in reported window; tone  out  1  hysteretic detection flag.

Function
REQ-009 SHALL capture fir_out only on a 0->1 transition of fir_rdy; a level held high SHALL yield exactly one capture.
REQ-010 SHALL form sample from fir_out[35:20]; if fir_out[47:35] are not all equal, it SHALL clamp to 32767 (sign 0) or -32768 (sign 1) and flag saturation.
REQ-011 SHALL register sample and pulse sample_vld exactly 1 cycle after the capture cycle.
REQ-012 SHALL compute magnitude = |sample|, with -32768 mapping to 32767.
REQ-013 SHALL count samples modulo 2^WIN_LOG2 and keep a running maximum magnitude plus a sticky saturation flag per window.
REQ-014 On the last sample of a window, peak SHALL load max(running max, current magnitude), clip SHALL load the window saturation flag including the current sample, peak_vld SHALL pulse 2 cycles after the capture cycle, and running max/flag SHALL clear so the next window starts from 0.
REQ-015 peak and clip SHALL hold their values between peak_vld strobes.
REQ-016 SHALL implement FSM QUIET/ACTIVE/HOLD, evaluated only in peak_vld cycles; tone = 1 in ACTIVE and HOLD.
REQ-017 QUIET->ACTIVE when peak >= THR_ON; otherwise QUIET is held.
REQ-018 ACTIVE->HOLD with quiet count = 1 when peak < THR_OFF; if HOLD_WIN = 1, ACTIVE->QUIET directly.
REQ-019 In HOLD: if peak >= THR_OFF -> ACTIVE and clear count; else increment count, entering QUIET when count reaches HOLD_WIN.
REQ-020 tone SHALL change in the same cycle peak_vld is asserted (registered together with peak).

Reset
REQ-021 Reset SHALL clear sample, sample_vld, peak, peak_vld, clip, tone, counters, and running max, and SHALL set the FSM to QUIET.
REQ-022 The fir_rdy edge-detect register SHALL reset to 1, so fir_rdy high at reset release produces no capture.
REQ-023 Reset mid-window SHALL discard the partial window; the first peak_vld after reset SHALL follow a full 2^WIN_LOG2 samples.

Structure
REQ-024 Package fir_meter_pkg SHALL hold the FSM state enum, SAMPLE_MAX/SAMPLE_MIN constants, and the slice position (MSB 35, LSB 20).
REQ-025 Saturation plus magnitude SHALL be one sub-module, fir_out_sat (combinational in, saturated sample, magnitude, sat flag out); all other logic stays in fir_level_meter.

Verification (bench uses WIN_LOG2 = 3, defaults otherwise)
REQ-026 Hold reset, then release -> all outputs 0 and tone 0; with fir_rdy = 1 across release, no sample_vld occurs.
REQ-027 fir_out = 48'h0001_2340_0000 with a fir_rdy edge -> sample = 16'h1234 and sample_vld 1 cycle later; fir_rdy held 20 cycles -> one strobe only.
REQ-028 fir_out = 48'h0010_0000_0000 -> sample 32767; 48'hFFF0_0000_0000 -> sample -32768, magnitude 32767; clip = 1 at that window's peak_vld and 0 in the next clean window.
REQ-029 Eight samples 100, -300, 200, 0, 50, -50, 299, 1 -> peak = 300 with peak_vld 2 cycles after the 8th edge; the next window of all-10 samples -> peak = 10.
REQ-030 Window peaks 9000, 5000, 3000, 3000 -> tone 1, 1, 1, 0 (states ACTIVE, ACTIVE, HOLD, QUIET); peaks 9000, 3000, 4500 -> tone stays 1 (back to ACTIVE).
REQ-031 Reset asserted after 5 samples of a window -> the next peak_vld occurs only after 8 further samples, and the pre-reset maximum is excluded.
